uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive buffer sitting directly downstream of the UART receiver and upstream of the APB UART slave register interface. Each one-cycle rx_done pulse pushes the received byte. The APB side pops bytes at its own pace, so back-to-back characters are no longer lost while software is slow. Reports level, almost-full and a sticky overrun flag; an optional receive-timeout flag is available.

Parameters:
DEPTH, 16, number of byte entries; power of two, minimum 2
DATA_W, 8, entry width
AFULL_LVL, 12, level at or above which afull asserts; range 1..DEPTH
TO_TICKS, 640, br_tick count for the timeout (4 characters x 160 ticks); used only with the optional feature

Ports:
clk  in  1  system clock (PCLK at the top level)
reset  in  1  asynchronous, active-high reset (PRESET at the top level)
wr_en  in  1  push strobe; driven by receiver rx_done
wr_data  in  DATA_W  byte to push; driven by receiver rx_data
rd_en  in  1  pop strobe from the APB slave; one pulse per byte
rd_data  out  DATA_W  head entry, first-word-fall-through
empty  out  1  level == 0
full  out  1  level == DEPTH
level  out  $clog2(DEPTH)+1  number of stored entries
afull  out  1  level >= AFULL_LVL
overrun  out  1  sticky; set when a push is dropped
ovr_clr  in  1  clears overrun
flush  in  1  discards all contents
br_tick  in  1  16x-oversample tick from the baud generator; used only with the timeout feature
rx_timeout  out  1  timeout flag; tied to 0 without the feature

Behaviour:
- Reset (async): rd_ptr=0, wr_ptr=0, level=0, overrun=0, rx_timeout=0. Resulting outputs: empty=1, full=0, afull=0, rd_data=0. Storage contents are don't-care.
- Pointers: $clog2(DEPTH) bits each; natural wrap from DEPTH-1 to 0. level is a separate counter of $clog2(DEPTH)+1 bits.
- rd_data: combinational mem[rd_ptr] when !empty; 0 when empty.
- Push: on wr_en && !full, mem[wr_ptr]<=wr_data, wr_ptr++, level++. Written data is visible on rd_data the next cycle, so push-to-head latency is 1 cycle.
- Pop: on rd_en && !empty, rd_ptr++, level--. The next entry appears on rd_data the following cycle.
- Pop while empty: ignored. No pointer or level change, no error flag.
- Push while full and no pop in the same cycle: byte dropped, overrun<=1, no state change.
- Push and pop in the same cycle:
  - Not empty and not full: both happen, level unchanged.
  - Full: both happen, no overrun.
  - Empty: push only, level becomes 1.
- overrun: sticky until ovr_clr. If ovr_clr and a new overrun occur in the same cycle, set wins.
- flush: rd_ptr=wr_ptr=0, level=0 on the next edge. flush has priority over a same-cycle wr_en and rd_en; that push is discarded without setting overrun. overrun is unaffected by flush.
- All flags are derived from registered level; none are registered separately.

Optional Feature:
Macro: UART_RX_FIFO_TIMEOUT_EN
- Defined:
  - A tick counter, $clog2(TO_TICKS+1) bits, is cleared on push, pop, flush, reset, or while empty.
  - Otherwise it increments on br_tick and saturates at TO_TICKS.
  - rx_timeout = (counter == TO_TICKS) && !empty, so it drops on the next push, pop or flush.
- Not defined: no counter logic; rx_timeout tied to 0; br_tick unused.

Decomposition:
- Package uart_pkg: UART_DATA_W=8, RX_FIFO_DEPTH=16, RX_FIFO_AFULL=12, RX_TO_TICKS=640, and typedef logic [UART_DATA_W-1:0] uart_byte_t. Parameter defaults come from the package.
- One sub-module, fifo_mem:
  - DEPTH x DATA_W register array.
  - Synchronous write port (we, waddr, wdata).
  - Asynchronous read port (raddr, rdata).
  - No reset on storage.
- Pointer, level, flag and timeout logic live in uart_rx_fifo.

Test Plan:
- After reset, push 0xA5, wait 1 cycle -> rd_data=0xA5, level=1, empty=0; pop -> empty=1, rd_data=0x00.
- Push 16 bytes 0x00..0x0F -> afull=1 from level 12, full=1 at 16. Push 0xEE -> overrun=1 and level=16. Pop 16 -> bytes 0x00..0x0F in order, 0xEE never seen.
- Fill to 16, then push 0x55 and pop in the same cycle -> overrun=0, level=16, and 0x55 is read out last after 15 further pops. Verifies pointer wrap.
- Empty FIFO, pop+push 0x3C in the same cycle -> level=1, rd_data=0x3C. Then pop only on the empty FIFO -> level stays 0.
- Level 5 with overrun=1, then flush and push in the same cycle -> level=0, empty=1, overrun still 1. Then ovr_clr -> overrun=0. Also ovr_clr with a same-cycle dropped push at full -> overrun stays 1.
- With UART_RX_FIFO_TIMEOUT_EN and TO_TICKS=4: push 1 byte, give 4 br_ticks -> rx_timeout=1. Pop -> rx_timeout=0 next cycle. Without the macro -> rx_timeout stays 0 throughout.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and types; supplies the default parameters of the receive FIFO.
package uart_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int RX_FIFO_DEPTH = 16;
  localparam int RX_FIFO_AFULL = 12;
  localparam int RX_TO_TICKS   = 640;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive-FIFO bus: the push side (UART receiver), the pop side (APB slave), and status.
// The master modport is the user of the FIFO, and the slave modport is the FIFO itself.
interface uart_rx_fifo_if #(
  parameter int DEPTH  = uart_pkg::RX_FIFO_DEPTH,
  parameter int DATA_W = uart_pkg::UART_DATA_W
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic [LVL_W-1:0]  level;
  logic              afull;
  logic              overrun;
  logic              ovr_clr;
  logic              flush;
  logic              br_tick;
  logic              rx_timeout;

  modport master (
    output wr_en, wr_data, rd_en, ovr_clr, flush, br_tick,
    input  rd_data, empty, full, level, afull, overrun, rx_timeout
  );

  modport slave (
    input  wr_en, wr_data, rd_en, ovr_clr, flush, br_tick,
    output rd_data, empty, full, level, afull, overrun, rx_timeout
  );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array with a synchronous write port and an asynchronous read port.
module fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              PCLK,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; rd_data is masked while empty, so stale contents are never seen.
  always_ff @(posedge PCLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer between the receiver and the APB slave: FWFT FIFO with level, afull
// and a sticky overrun. Optional receive timeout is enabled by defining UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = RX_FIFO_DEPTH,
  parameter int DATA_W    = UART_DATA_W,
  parameter int AFULL_LVL = RX_FIFO_AFULL,
  parameter int TO_TICKS  = RX_TO_TICKS
) (
  input logic         PCLK,
  input logic         PRESET,
  uart_rx_fifo_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [LVL_W-1:0]  level_q;
  logic              overrun_q;
  logic              empty, full;
  logic              pop, push, drop;
  logic [DATA_W-1:0] mem_rdata;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_W'(DEPTH));

  // A pop frees a slot in the same cycle, so a push at full is accepted alongside a pop.
  assign pop  = bus.rd_en && !empty;
  assign push = bus.wr_en && (!full || pop);
  assign drop = bus.wr_en && !push;

  fifo_mem #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem (
    .PCLK  (PCLK),
    .we    (push && !bus.flush),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
    end else if (bus.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // A push discarded by flush is not an overrun; a new overrun wins over a same-cycle clear.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                   overrun_q <= 1'b0;
    else if (drop && !bus.flush)  overrun_q <= 1'b1;
    else if (bus.ovr_clr)         overrun_q <= 1'b0;
  end

  assign bus.rd_data = empty ? '0 : mem_rdata;
  assign bus.empty   = empty;
  assign bus.full    = full;
  assign bus.level   = level_q;
  assign bus.afull   = (level_q >= LVL_W'(AFULL_LVL));
  assign bus.overrun = overrun_q;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_TICKS + 1);

  logic [TO_W-1:0] to_cnt;

  // Counts idle baud ticks while data sits unread; any FIFO activity restarts it.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                                       to_cnt <= '0;
    else if (push || pop || bus.flush || empty)       to_cnt <= '0;
    else if (bus.br_tick && to_cnt != TO_W'(TO_TICKS)) to_cnt <= to_cnt + TO_W'(1);
  end

  assign bus.rx_timeout = (to_cnt == TO_W'(TO_TICKS)) && !empty;
`else
  logic unused_br_tick;
  assign unused_br_tick = bus.br_tick;
  assign bus.rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: queue-based reference model, monitor checks status every
// cycle and pops/compares head data on each accepted read. Timeout expectations follow UART_RX_FIFO_TIMEOUT_EN.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH    = RX_FIFO_DEPTH;
  localparam int DATA_W   = UART_DATA_W;
  localparam int AFULL    = RX_FIFO_AFULL;
  localparam int TO_TICKS = 4;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic PCLK   = 1'b0;
  logic PRESET = 1'b1;
  always #5 PCLK = ~PCLK;

  uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  uart_rx_fifo #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .AFULL_LVL(AFULL), .TO_TICKS(TO_TICKS)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: expected byte order, occupancy, sticky overrun, idle tick count.
  uart_byte_t exp_q[$];
  int         model_lvl = 0;
  bit         model_ovr = 1'b0;
  int         idle      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, updated at each active edge from the inputs presented in that cycle.
  initial begin
    forever begin
      @(posedge PCLK or posedge PRESET);
      if (PRESET) begin
        exp_q.delete();
        model_lvl = 0;
        model_ovr = 1'b0;
        idle      = 0;
      end else begin
        int pre;
        bit pop_ok, push_ok, dropped;
        pre     = model_lvl;
        pop_ok  = bus.rd_en && (pre > 0);
        push_ok = bus.wr_en && ((pre < DEPTH) || pop_ok);
        dropped = bus.wr_en && !push_ok;
        if (bus.flush) begin
          exp_q.delete();
          model_lvl = 0;
        end else begin
          model_lvl = pre - int'(pop_ok) + int'(push_ok);
          if (push_ok) exp_q.push_back(bus.wr_data);
        end
        if (dropped && !bus.flush) model_ovr = 1'b1;
        else if (bus.ovr_clr)      model_ovr = 1'b0;
        if (bus.flush || push_ok || pop_ok || pre == 0) idle = 0;
        else if (bus.br_tick)                            idle++;
      end
    end
  end

  // Monitor: status every cycle; head data checked and retired on each accepted pop.
  initial begin
    forever begin
      @(negedge PCLK);
      check("level",      32'(bus.level),  32'(model_lvl));
      check("empty",      32'(bus.empty),  32'(model_lvl == 0));
      check("full",       32'(bus.full),   32'(model_lvl == DEPTH));
      check("afull",      32'(bus.afull),  32'(model_lvl >= AFULL));
      check("overrun",    32'(bus.overrun), 32'(model_ovr));
      check("rx_timeout", 32'(bus.rx_timeout),
            32'(TO_EN && model_lvl > 0 && idle >= TO_TICKS));
      if (model_lvl == 0) begin
        check("rd_data_empty", 32'(bus.rd_data), 32'(0));
      end else if (bus.rd_en && !bus.flush && !PRESET) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 32'(exp_q.size()), 32'(1));
        end else begin
          uart_byte_t e;
          e = exp_q.pop_front();
          check("rd_data", 32'(bus.rd_data), 32'(e));
        end
      end
    end
  end

  task automatic cyc(input bit wr, input logic [7:0] d, input bit rd,
                     input bit fl = 1'b0, input bit oc = 1'b0, input bit tk = 1'b0);
    bus.wr_en   = wr;
    bus.wr_data = d;
    bus.rd_en   = rd;
    bus.flush   = fl;
    bus.ovr_clr = oc;
    bus.br_tick = tk;
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0;
    bus.flush = 1'b0; bus.ovr_clr = 1'b0; bus.br_tick = 1'b0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    cyc(0, 8'h00, 0);

    // Single byte round trip
    cyc(1, 8'hA5, 0);
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);

    // Fill, overflow, drain in order
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0);
    cyc(1, 8'hEE, 0);
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0, 0, 1);

    // Push+pop at full, then drain across the pointer wrap
    for (int i = 0; i < 16; i++) cyc(1, 8'($urandom_range(0, 255)), 0);
    cyc(1, 8'h55, 1);
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1);

    // Push+pop on empty, then pop on empty
    cyc(1, 8'h3C, 1);
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 1);

    // Flush with same-cycle push at level 5 and overrun set
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h80 + i), 0);
    cyc(1, 8'hEE, 0);
    for (int i = 0; i < 11; i++) cyc(0, 8'h00, 1);
    cyc(1, 8'h77, 0, 1);
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0);
    cyc(1, 8'hDD, 0, 0, 1);
    cyc(0, 8'h00, 0, 1, 1);

    // Idle ticks with one stored byte, then pop
    cyc(1, 8'h42, 0);
    for (int i = 0; i < 6; i++) cyc(0, 8'h00, 0, 0, 0, 1);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0, 0, 0, 1);

    // Randomized traffic with phases biased toward filling and draining
    for (int i = 0; i < 3000; i++) begin
      int wr_pct;
      wr_pct = ((i / 200) % 2 == 0) ? 70 : 30;
      cyc($urandom_range(0, 99) < wr_pct,
          8'($urandom_range(0, 255)),
          $urandom_range(0, 99) < (100 - wr_pct),
          $urandom_range(0, 99) < 2,
          $urandom_range(0, 99) < 5,
          $urandom_range(0, 99) < 40);
    end
    cyc(0, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
